param_register_file: RTL and testbench

PARAM_REGISTER_FILE -- requirements
Module: param_register_file

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_read_port.sv | 54 +++++
 rtl/param_register_file.sv | 139 +++++++++++++
 tb/tb_param_register_file.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the parameterised register file: default parameter
// values, FSM state encoding and initialisation-mode encodings.
package regfile_pkg;

    // Default parameter values
    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_ADDR_W   = 5;
    localparam int unsigned DEF_N_READ   = 2;
    localparam int unsigned DEF_ZERO_REG = 1;

    // INIT_MODE encodings: what the sweep writes into register i
    localparam int unsigned INIT_ZERO  = 0;  // every register cleared to zero
    localparam int unsigned INIT_INDEX = 1;  // register i loaded with value i

    localparam int unsigned DEF_INIT_MODE = INIT_INDEX;

    // Controller states: SWEEP walks the whole array re-initialising it
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// One registered read port: write-through bypass, zero-register mask and a
// forced-zero output while the array is being swept.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned ZERO_REG = DEF_ZERO_REG
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sweep,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_wr_accept,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] w_rd_nxt;
    logic [DATA_W-1:0] r_rd_data;
    logic              w_bypass;
    logic              w_zero_hit;

    assign w_bypass   = i_wr_accept && (i_wr_addr == i_rd_addr);
    assign w_zero_hit = (ZERO_REG != 0) && (i_rd_addr == '0);

    // Select read data; later conditions take priority over earlier ones
    always_comb begin
        w_rd_nxt = i_mem_data;
        if (w_bypass) begin
            w_rd_nxt = i_wr_data;
        end
        if (w_zero_hit) begin
            w_rd_nxt = '0;
        end
        if (i_sweep) begin
            w_rd_nxt = '0;
        end
    end

    // Output register, one cycle of read latency
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_nxt;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : regfile_read_port

// File: rtl/param_register_file.sv
// Parameterised multi-port register file with a sweep controller that
// re-initialises every register after reset or on request, a set of
// registered read ports with write-through bypass, and a debug read port.
module param_register_file
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned N_READ    = DEF_N_READ,
    parameter int unsigned ZERO_REG  = DEF_ZERO_REG,
    parameter int unsigned INIT_MODE = DEF_INIT_MODE
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [N_READ*ADDR_W-1:0]   i_rd_addr,
    output logic [N_READ*DATA_W-1:0]   o_rd_data,
    input  logic                       i_wr_en,
    input  logic [ADDR_W-1:0]          i_wr_addr,
    input  logic [DATA_W-1:0]          i_wr_data,
    input  logic                       i_clear_req,
    output logic                       o_clear_busy,
    input  logic [ADDR_W-1:0]          i_dbg_addr,
    output logic [DATA_W-1:0]          o_dbg_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = '1;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic              w_sweep;
    logic [DATA_W-1:0] w_init_data;
    logic              w_wr_zero;
    logic              w_wr_accept;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dbg_data;

    assign w_sweep = (r_state == SWEEP);

    // Sweep controller next state: IDLE waits for a clear request, SWEEP
    // advances one register per cycle and ends after the last address
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        unique case (r_state)
            IDLE: begin
                if (i_clear_req) begin
                    w_state_nxt = SWEEP;
                    w_ptr_nxt   = '0;
                end
            end
            SWEEP: begin
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == LAST_PTR) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = SWEEP;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // Reset lands in SWEEP so the array is initialised as soon as reset drops
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SWEEP;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Value written by the sweep at the current pointer
    always_comb begin
        w_init_data = '0;
        if (INIT_MODE == INIT_INDEX) begin
            w_init_data = DATA_W'(r_ptr);
        end
    end

    // A write lands only in IDLE, not when a sweep is being requested in the
    // same cycle, and never into a hardwired zero register
    assign w_wr_zero   = (ZERO_REG != 0) && (i_wr_addr == '0);
    assign w_wr_accept = !w_sweep && i_wr_en && !i_clear_req && !w_wr_zero;

    // Storage array has no reset; during reset the controller sits in SWEEP at
    // pointer 0, which blocks user writes
    always_ff @(posedge i_clk) begin
        if (w_sweep) begin
            r_mem[r_ptr] <= w_init_data;
        end else if (w_wr_accept) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // One read port per address lane
    for (genvar k = 0; k < N_READ; k++) begin : g_rd_port
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_mem_data;

        assign w_addr     = i_rd_addr[k*ADDR_W +: ADDR_W];
        assign w_mem_data = r_mem[w_addr];

        regfile_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .i_sweep     (w_sweep),
            .i_rd_addr   (w_addr),
            .i_mem_data  (w_mem_data),
            .i_wr_accept (w_wr_accept),
            .i_wr_addr   (i_wr_addr),
            .i_wr_data   (i_wr_data),
            .o_rd_data   (o_rd_data[k*DATA_W +: DATA_W])
        );
    end

    // Debug port shows stored contents only: no bypass, active during SWEEP
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dbg_data <= '0;
        end else begin
            r_dbg_data <= r_mem[i_dbg_addr];
        end
    end

    assign o_clear_busy = w_sweep;
    assign o_dbg_data   = r_dbg_data;

endmodule : param_register_file

// File: tb/tb_param_register_file.sv
// Scoreboard bench for param_register_file: stimulus pushes expected read
// results into a queue tagged with the cycle they appear; a monitor compares
// them on the falling edge.
module tb_param_register_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;

    typedef struct {
        int          due;
        int          kind;   // 0 = read port, 1 = debug port
        int          port;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              clear_req;
    logic              clear_busy;
    logic [AW-1:0]     dbg_addr;
    logic [DW-1:0]     dbg_data;

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic [31:0] mon_act;

    param_register_file #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .N_READ    (NR),
        .ZERO_REG  (1),
        .INIT_MODE (1)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rd_addr    (rd_addr),
        .o_rd_data    (rd_data),
        .i_wr_en      (wr_en),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .i_clear_req  (clear_req),
        .o_clear_busy (clear_busy),
        .i_dbg_addr   (dbg_addr),
        .o_dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every expectation due at this cycle
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            if (mon_e.kind == 0) mon_act = rd_data[mon_e.port*DW +: DW];
            else                 mon_act = dbg_data;
            check(mon_e.name, mon_act, mon_e.val);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_rd(input int port, input logic [31:0] v, input string name);
        sb_q.push_back('{cyc + 1, 0, port, v, name});
    endtask

    task automatic exp_dbg(input logic [31:0] v, input string name);
        sb_q.push_back('{cyc + 1, 1, 0, v, name});
    endtask

    task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
        rd_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endtask

    task automatic write(input int a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
    endtask

    // Count rising edges while busy; a full sweep is 32 cycles
    task automatic wait_sweep(input int start, input string name);
        int n;
        n = start;
        while (clear_busy === 1'b1 && n < 200) begin
            step();
            n++;
        end
        check(name, n, 32);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation timed out at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        rd_addr   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        clear_req = 1'b0;
        dbg_addr  = '0;

        // Reset state
        repeat (3) step();
        check("rst_rd_data_lo", rd_data[63:0], 64'h0);
        check("rst_rd_data_hi", rd_data[127:64], 64'h0);
        check("rst_dbg", dbg_data, 32'h0);
        check("rst_busy", {31'b0, clear_busy}, 32'h1);

        // Sweep after reset release, then initial contents
        rst_n = 1'b1;
        wait_sweep(0, "post_reset_busy_cycles");
        set_rd(7, 0, 31, 1);
        dbg_addr = 5'd7;
        exp_rd(0, 32'd7, "init_addr7");
        exp_rd(1, 32'd0, "init_addr0");
        exp_rd(2, 32'd31, "init_addr31");
        exp_rd(3, 32'd1, "init_addr1");
        exp_dbg(32'd7, "init_dbg7");
        step();

        // Bypass on write; debug sees old value
        write(5, 32'hDEADBEEF);
        set_rd(5, 6, 5, 7);
        dbg_addr = 5'd5;
        exp_rd(0, 32'hDEADBEEF, "bypass_p0");
        exp_rd(1, 32'd6, "bypass_other_p1");
        exp_rd(2, 32'hDEADBEEF, "bypass_p2");
        exp_dbg(32'd5, "bypass_dbg_old");
        step();
        wr_en = 1'b0;
        exp_rd(0, 32'hDEADBEEF, "stored_p0");
        exp_dbg(32'hDEADBEEF, "stored_dbg");
        step();

        // Register 0 stays zero, with and without bypass
        write(0, 32'h1234);
        set_rd(0, 0, 5, 0);
        dbg_addr = 5'd0;
        exp_rd(0, 32'd0, "zero_bypass_p0");
        exp_rd(1, 32'd0, "zero_bypass_p1");
        step();
        wr_en = 1'b0;
        exp_rd(0, 32'd0, "zero_stored_p0");
        exp_rd(1, 32'd0, "zero_stored_p1");
        exp_dbg(32'd0, "zero_stored_dbg");
        step();

        // All four ports on one address
        write(9, 32'h55);
        set_rd(9, 9, 9, 9);
        for (int k = 0; k < NR; k++) exp_rd(k, 32'h55, $sformatf("same_addr_bypass_p%0d", k));
        step();
        wr_en = 1'b0;
        for (int k = 0; k < NR; k++) exp_rd(k, 32'h55, $sformatf("same_addr_p%0d", k));
        step();

        // Clear request wins over a same-cycle write
        write(3, 32'hAA);
        set_rd(3, 4, 0, 0);
        exp_rd(0, 32'hAA, "pre_clear_bypass3");
        step();
        write(4, 32'hBB);
        clear_req = 1'b1;
        set_rd(4, 3, 0, 0);
        dbg_addr = 5'd3;
        exp_rd(0, 32'd4, "clear_cycle_write_dropped");
        exp_rd(1, 32'hAA, "clear_cycle_p1");
        exp_dbg(32'hAA, "clear_cycle_dbg");
        step();
        // In sweep: reads are zero, writes and a second clear are ignored
        write(6, 32'h77);
        clear_req = 1'b1;
        set_rd(6, 9, 0, 0);
        dbg_addr = 5'd9;
        exp_rd(0, 32'd0, "sweep_rd_p0_zero");
        exp_rd(1, 32'd0, "sweep_rd_p1_zero");
        exp_dbg(32'h55, "sweep_dbg_stored");
        step();
        wr_en     = 1'b0;
        clear_req = 1'b0;
        wait_sweep(1, "clear_busy_cycles");
        set_rd(3, 4, 6, 5);
        dbg_addr = 5'd5;
        exp_rd(0, 32'd3, "after_clear_addr3");
        exp_rd(1, 32'd4, "after_clear_addr4");
        exp_rd(2, 32'd6, "after_clear_addr6");
        exp_rd(3, 32'd5, "after_clear_addr5");
        exp_dbg(32'd5, "after_clear_dbg5");
        step();

        // Reset in the middle of a sweep restarts it from pointer 0
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        check("midsweep_rst_busy", {31'b0, clear_busy}, 32'h1);
        check("midsweep_rst_rd0", rd_data[31:0], 32'h0);
        check("midsweep_rst_dbg", dbg_data, 32'h0);
        repeat (2) step();
        rst_n = 1'b1;
        wait_sweep(0, "midsweep_restart_busy_cycles");
        set_rd(10, 11, 0, 31);
        exp_rd(0, 32'd10, "restart_addr10");
        exp_rd(1, 32'd11, "restart_addr11");
        exp_rd(2, 32'd0, "restart_addr0");
        exp_rd(3, 32'd31, "restart_addr31");
        step();

        repeat (2) step();
        check("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_param_register_file
